cordic_sched: RTL and testbench

Sequencer and round-robin arbiter that shares one `cordic` sin/cos core between `N_REQ` requesters. Per job it:
- reduces the angle into the core's convergence range;
- restarts the core by pulsing its reset, runs it, and waits for `done`;
- corrects the result sign and applies the requester's `opt` mask;
- returns the result on one shared response channel tagged with the requester id.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/cordic_sched.sv | 172 +++++++++++++++++
 tb/tb_cordic_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the cordic job scheduler
//
// Purpose: Q16.16 angle type, angle-range constants, opt encodings and the
//          scheduler state enum. Imported by cordic_sched.
// Ports:   none (package).
package cordic_pkg;

  // Signed Q16.16 fixed-point angle in radians.
  typedef logic signed [31:0] angle_q16_t;

  localparam angle_q16_t PI_Q16      = 32'sd205887;
  localparam angle_q16_t HALF_PI_Q16 = 32'sd102944;

  // Requester opt encodings. 00 and 10 both return sin and cos.
  localparam logic [1:0] OPT_SINCOS   = 2'b00;
  localparam logic [1:0] OPT_COS_ONLY = 2'b01;
  localparam logic [1:0] OPT_SINCOS_B = 2'b10;
  localparam logic [1:0] OPT_NONE     = 2'b11;

  // The core is always asked for both results; masking is done here.
  localparam logic [1:0] CORE_OPT = OPT_SINCOS_B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational N-way round-robin arbiter
//
// Purpose: grants the first asserted request at or after ptr, wrapping around.
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  highest-priority index this cycle
//   grant out N   one-hot grant, all zero when no request
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int idx;

  // Walk from the farthest position back toward ptr so the request closest
  // to ptr is the last writer and wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - round-robin job sequencer sharing one cordic sin/cos core
//
// Purpose: accepts one angle job at a time from N_REQ requesters, reduces the
//          angle into the core's range, pulses the core reset, runs the core,
//          sign-corrects and masks the result and returns it tagged with the
//          requester id. Out-of-range angles and core timeouts return rsp_err.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot)
//   req_angle, req_opt       packed per-requester Q16.16 angle and opt
//   rsp_valid/rsp_ready      shared response handshake
//   rsp_id, rsp_sin, rsp_cos, rsp_err   response payload
//   busy                     high whenever a job is in flight
//   core_*                   control/data to and from the shared cordic core
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [32*N_REQ-1:0] req_angle,
  input  logic [2*N_REQ-1:0] req_opt,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_id,
  output logic [31:0]        rsp_sin,
  output logic [31:0]        rsp_cos,
  output logic               rsp_err,
  output logic               busy,
  output logic               core_reset,
  output logic               core_enable,
  output logic [31:0]        core_angle,
  output logic [1:0]         core_opt,
  input  logic [31:0]        core_sin,
  input  logic [31:0]        core_cos,
  input  logic               core_done
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  gidx;
  logic [N_REQ-1:0] grant;
  logic [1:0]     opt_q;
  logic           flip;
  logic [TW-1:0]  tmo_cnt;

  angle_q16_t     sel_angle;
  logic [1:0]     sel_opt;
  angle_q16_t     red_angle;
  logic           red_flip;
  logic           out_of_range;
  angle_q16_t     fix_sin;
  angle_q16_t     fix_cos;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grants are offered only while idle, so a job is never accepted while
  // another is in flight.
  assign req_ready  = (state == IDLE) ? grant : '0;
  assign busy       = (state != IDLE);
  assign core_reset = reset | (state == CLR);
  assign core_opt   = CORE_OPT;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  assign sel_angle    = $signed(req_angle[32*gidx +: 32]);
  assign sel_opt      = req_opt[2*gidx +: 2];
  assign out_of_range = (sel_angle > PI_Q16) || (sel_angle < -PI_Q16);

  // Fold |a| > pi/2 onto the opposite half-plane; sin and cos both change
  // sign under a shift by pi, which flip undoes after the core finishes.
  always_comb begin
    red_angle = sel_angle;
    red_flip  = 1'b0;
    if (sel_angle > HALF_PI_Q16) begin
      red_angle = sel_angle - PI_Q16;
      red_flip  = 1'b1;
    end else if (sel_angle < -HALF_PI_Q16) begin
      red_angle = sel_angle + PI_Q16;
      red_flip  = 1'b1;
    end
  end

  assign fix_sin = flip ? -$signed(core_sin) : $signed(core_sin);
  assign fix_cos = flip ? -$signed(core_cos) : $signed(core_cos);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sin     <= '0;
      rsp_cos     <= '0;
      rsp_err     <= 1'b0;
      core_enable <= 1'b0;
      core_angle  <= '0;
      opt_q       <= '0;
      flip        <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            rr_ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
            rsp_id <= 3'(gidx);
            opt_q  <= sel_opt;
            if (out_of_range) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_sin   <= '0;
              rsp_cos   <= '0;
            end else begin
              state      <= CLR;
              core_angle <= red_angle;
              flip       <= red_flip;
            end
          end
        end
        CLR: begin
          state       <= RUN;
          core_enable <= 1'b1;
          tmo_cnt     <= '0;
        end
        RUN: begin
          if (core_done) begin
            state       <= RESP;
            core_enable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_sin     <= (opt_q == OPT_COS_ONLY || opt_q == OPT_NONE) ? '0 : fix_sin;
            rsp_cos     <= (opt_q == OPT_NONE) ? '0 : fix_cos;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state       <= RESP;
            core_enable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_sin     <= '0;
            rsp_cos     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - scoreboard testbench for cordic_sched with a behavioural core stub
module tb_cordic_sched;

  localparam int N   = 4;
  localparam int TMO = 24;
  localparam int PI_Q = 205887;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_angle = '0;
  logic [2*N-1:0]  req_opt = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [2:0]      rsp_id;
  logic [31:0]     rsp_sin, rsp_cos;
  logic            rsp_err, busy, core_reset, core_enable;
  logic [31:0]     core_angle;
  logic [1:0]      core_opt;
  logic [31:0]     core_sin = '0, core_cos = '0;
  logic            core_done;

  always #5 clk = ~clk;

  cordic_sched #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_angle(req_angle), .req_opt(req_opt), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_err(rsp_err), .busy(busy),
    .core_reset(core_reset), .core_enable(core_enable), .core_angle(core_angle),
    .core_opt(core_opt), .core_sin(core_sin), .core_cos(core_cos), .core_done(core_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int q16(input real x);
    real s;
    s = x * 65536.0;
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
  endfunction

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input longint act, input longint exp, input longint tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  // Core stub: loads on the first enabled cycle after reset, done 18 enabled
  // cycles later, returning ideal sin/cos of the loaded angle.
  int   core_cnt = 0;
  logic core_stuck = 1'b0;
  assign core_done = !core_stuck && (core_cnt >= 18);

  always @(posedge clk) begin
    if (core_reset) begin
      core_cnt <= 0;
    end else if (core_enable) begin
      if (core_cnt == 0) begin
        core_sin <= 32'(q16($sin($itor($signed(core_angle)) / 65536.0)));
        core_cos <= 32'(q16($cos($itor($signed(core_angle)) / 65536.0)));
      end
      if (core_cnt < 100) core_cnt <= core_cnt + 1;
    end
  end

  typedef struct {
    int id;
    int angle;
    int opt;
    int t;
    bit oor;
    bit err;
  } exp_t;

  exp_t sbq[$];
  int   gids[$];
  int   cyc = 0;
  int   mptr = 0;
  logic [N-1:0] last_grant = '0;
  bit   prev_valid = 0, prev_hold = 0;
  logic [2:0]  p_id;
  logic [31:0] p_sin, p_cos;
  logic        p_err;

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) begin
        r[(p + k) % N] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  // Monitor: arbitration model, scoreboard push on transfer, pop on response.
  always @(negedge clk) begin
    logic [N-1:0] g;
    exp_t e;
    int   idx;
    cyc++;
    last_grant = '0;
    if (reset) begin
      sbq.delete();
      mptr = 0;
      prev_valid = 0;
      prev_hold = 0;
    end else begin
      if (!busy) chk_eq("req_ready_rr", req_ready, rr_pick(req_valid, mptr));
      else if (req_valid != 0) chk_eq("req_ready_busy", req_ready, 0);
      g = req_valid & req_ready;
      if (g != 0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (g[i]) idx = i;
        e.id    = idx;
        e.angle = $signed(req_angle[32*idx +: 32]);
        e.opt   = int'(req_opt[2*idx +: 2]);
        e.t     = cyc;
        e.oor   = (e.angle > PI_Q) || (e.angle < -PI_Q);
        e.err   = e.oor || core_stuck;
        sbq.push_back(e);
        gids.push_back(idx);
        mptr = (idx + 1) % N;
        last_grant = g;
      end
      if (core_enable && sbq.size() != 0 && sbq[0].oor) chk_eq("core_enable_on_err", core_enable, 0);
      if (prev_hold) begin
        chk_eq("hold_valid", rsp_valid, 1);
        chk_eq("hold_id", rsp_id, p_id);
        chk_eq("hold_sin", rsp_sin, p_sin);
        chk_eq("hold_cos", rsp_cos, p_cos);
        chk_eq("hold_err", rsp_err, p_err);
      end
      if (rsp_valid && !prev_valid) begin
        chk_eq("rsp_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0)
          chk_eq("latency", cyc - sbq[0].t, sbq[0].oor ? 1 : (sbq[0].err ? 2 + TMO : 21));
      end
      if (rsp_valid && rsp_ready && sbq.size() != 0) begin
        real a;
        e = sbq.pop_front();
        chk_eq("rsp_id", rsp_id, e.id);
        chk_eq("rsp_err", rsp_err, e.err);
        a = $itor(e.angle) / 65536.0;
        if (e.err || e.opt == 3) begin
          chk_eq("rsp_sin_zero", $signed(rsp_sin), 0);
          chk_eq("rsp_cos_zero", $signed(rsp_cos), 0);
        end else begin
          if (e.opt == 1) chk_eq("rsp_sin_masked", $signed(rsp_sin), 0);
          else chk_near("rsp_sin", $signed(rsp_sin), q16($sin(a)), 8);
          chk_near("rsp_cos", $signed(rsp_cos), q16($cos(a)), 8);
        end
      end
      prev_valid = rsp_valid;
      prev_hold  = rsp_valid && !rsp_ready;
      p_id = rsp_id; p_sin = rsp_sin; p_cos = rsp_cos; p_err = rsp_err;
    end
  end

  // Stimulus side.
  logic [N-1:0] pend = '0;
  int pang[N];
  int popt[N];
  int rmode = 0;

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_angle[32*i +: 32] = 32'(pang[i]);
      req_opt[2*i +: 2]     = 2'(popt[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pend = pend & ~last_grant;
    drive();
    rsp_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int i, input int ang, input int op);
    pend[i] = 1'b1;
    pang[i] = ang;
    popt[i] = op;
    drive();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((pend != 0 || sbq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk_eq("drain_in_budget", (pend != 0 || sbq.size() != 0 || busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend = '0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int bnd[8];
    for (int i = 0; i < N; i++) begin pang[i] = 0; popt[i] = 0; end
    tick(); tick(); tick();

    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_rsp_id", rsp_id, 0);
    chk_eq("rst_rsp_sin", rsp_sin, 0);
    chk_eq("rst_rsp_cos", rsp_cos, 0);
    chk_eq("rst_rsp_err", rsp_err, 0);
    chk_eq("rst_core_enable", core_enable, 0);
    chk_eq("rst_core_angle", core_angle, 0);
    chk_eq("rst_core_reset", core_reset, 1);
    chk_eq("core_opt", core_opt, 2);
    reset = 1'b0;
    tick();

    // Angle 0, sin and cos.
    issue(0, 0, 2);
    wait_done(60);

    // 2.0 rad folds to 2.0 - pi; CLR then RUN timing.
    issue(1, 131072, 0);
    tick();
    chk_eq("clr_core_reset", core_reset, 1);
    chk_eq("clr_core_enable", core_enable, 0);
    tick();
    chk_eq("core_angle_reduced", $signed(core_angle), -74815);
    chk_eq("run_core_enable", core_enable, 1);
    chk_eq("run_core_reset", core_reset, 0);
    wait_done(60);

    // Round-robin from reset: all four, then 0 and 2.
    do_reset();
    gids.delete();
    for (int i = 0; i < N; i++) issue(i, 20000 * i - 30000, i % 3);
    wait_done(200);
    chk_eq("rr_count4", gids.size(), 4);
    for (int i = 0; i < 4 && i < gids.size(); i++) chk_eq("rr_order4", gids[i], i);
    gids.delete();
    issue(0, 5000, 0);
    issue(2, -5000, 0);
    wait_done(100);
    chk_eq("rr_count2", gids.size(), 2);
    if (gids.size() == 2) begin
      chk_eq("rr_first", gids[0], 0);
      chk_eq("rr_second", gids[1], 2);
    end

    // Response stall with a competing request pending; opt 01.
    rmode = 1;
    issue(3, 50000, 1);
    for (int n = 0; n < 40 && !rsp_valid; n++) tick();
    chk_eq("stall_rsp_valid", rsp_valid, 1);
    issue(0, -60000, 0);
    repeat (10) tick();
    rmode = 0;
    wait_done(100);

    // Range errors.
    issue(2, 300000, 0);
    wait_done(20);
    issue(1, -300000, 2);
    wait_done(20);

    // Core that never finishes.
    core_stuck = 1'b1;
    issue(1, 1000, 0);
    wait_done(60);
    core_stuck = 1'b0;

    // Reset during RUN discards the job.
    issue(0, 40000, 0);
    repeat (10) tick();
    chk_eq("mid_run_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk_eq("mid_rst_idle", busy, 0);
    chk_eq("mid_rst_rsp_valid", rsp_valid, 0);
    chk_eq("mid_rst_core_reset", core_reset, 1);
    tick();
    chk_eq("mid_rst_core_reset_held", core_reset, 1);
    reset = 1'b0;
    repeat (5) tick();
    chk_eq("no_rsp_after_rst", rsp_valid, 0);
    issue(2, -150000, 2);
    wait_done(60);

    // Boundary angles.
    bnd[0] = 205887;  bnd[1] = -205887; bnd[2] = 205888;  bnd[3] = -205888;
    bnd[4] = 102944;  bnd[5] = -102944; bnd[6] = 102945;  bnd[7] = -102945;
    for (int k = 0; k < 8; k++) begin
      issue(k % N, bnd[k], 0);
      wait_done(60);
    end

    // Random traffic with random response back-pressure.
    rmode = 2;
    for (int j = 0; j < 40; j++) begin
      int i;
      i = $urandom_range(0, N - 1);
      if (!pend[i]) issue(i, $urandom_range(0, 500000) - 250000, $urandom_range(0, 3));
      repeat ($urandom_range(1, 20)) tick();
    end
    wait_done(2000);
    rmode = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
